// File: rtl/bsa_pkg.sv
// Shared types and default sizing for the bitstream buffer arbiter.
package bsa_pkg;

  localparam int BSA_NUM_REQ = 4;
  localparam int BSA_DATA_W  = 512;
  localparam int BSA_SRC_W   = $clog2(BSA_NUM_REQ);

  typedef enum logic {IDLE, LOCKED} bsa_state_t;

  typedef struct packed {
    logic [BSA_DATA_W-1:0] data;
    logic [BSA_SRC_W-1:0]  src;
    logic                  last;
  } bsa_word_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, cyclically.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW:0] s;

  always_comb begin
    gnt = '0;
    idx = '0;
    s   = '0;
    // Walk offsets high to low so the closest requester to ptr wins last.
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (req[s[IW-1:0]]) idx = s[IW-1:0];
    end
    if (|req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/bitstream_buffer_arbiter.sv
// Round-robin, burst-locking arbiter feeding one shared bitstream holding register.
// Define BSA_BURST_LIMIT_EN to cap locked bursts at MAX_BURST words (sets sticky burst_err).
module bitstream_buffer_arbiter
  import bsa_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = BSA_DATA_W,
  parameter  int MAX_BURST = 16,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      out_last,
  output logic                      full,
  output logic                      locked,
  output logic                      burst_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("bitstream_buffer_arbiter: unsupported NUM_REQ/MAX_BURST");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
    logic              last;
  } word_t;

  bsa_state_t           state;
  logic [SRC_W-1:0]     owner, rr_ptr, win_idx, pick_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  word_t                hold, win;
  logic                 vld, can_acc, acc, raw_last, force_last;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign can_acc = !vld || out_ready;

  always_comb begin
    gnt     = '0;
    win_idx = (state == LOCKED) ? owner : pick_idx;
    if (reset_n && can_acc) begin
      if (state == IDLE)  gnt = pick_gnt;
      else if (req[owner]) gnt[owner] = 1'b1;
    end
  end

  assign acc      = |gnt;
  assign raw_last = req_last[win_idx];

  always_comb begin
    win.data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    win.src  = win_idx;
    win.last = raw_last | force_last;
  end

`ifdef BSA_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;

  // Count includes the packet's first word, which is accepted from IDLE.
  assign cnt_nxt    = ((state == IDLE) ? '0 : burst_cnt) + 1'b1;
  assign force_last = acc && !raw_last && (cnt_nxt >= CNT_W'(MAX_BURST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
      burst_err <= 1'b0;
    end else if (acc) begin
      burst_cnt <= win.last ? '0 : cnt_nxt;
      if (force_last) burst_err <= 1'b1;
    end
  end
`else
  assign force_last = 1'b0;
  assign burst_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      hold   <= '0;
      vld    <= 1'b0;
    end else begin
      if (acc) begin
        hold <= win;
        vld  <= 1'b1;
      end else if (out_ready) begin
        hold <= '0;
        vld  <= 1'b0;
      end
      if (acc) begin
        if (state == IDLE)
          rr_ptr <= (pick_idx == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        if (win.last) begin
          state <= IDLE;
        end else begin
          state <= LOCKED;
          owner <= win_idx;
        end
      end
    end
  end

  assign out_valid = vld;
  assign full      = vld;
  assign out_data  = hold.data;
  assign out_src   = hold.src;
  assign out_last  = hold.last;
  assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_bitstream_buffer_arbiter.sv
// Directed bench: driver checks gnt/locked and queues expected words; monitor checks drained words.
module tb_bitstream_buffer_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int SW = 2;
`ifdef BSA_BURST_LIMIT_EN
  localparam int  MB  = 4;
  localparam bit  LIM = 1'b1;
`else
  localparam int  MB  = 16;
  localparam bit  LIM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, req_last, gnt;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_ready, out_last, full, locked, burst_err;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;

  logic [DW-1:0]   dat [N];
  logic [DW-1:0]   a5w;
  bit              ovr_en;
  int              ovr_src;
  int              tagc;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  for (genvar g = 0; g < N; g++) begin : g_data
    assign req_data[g*DW +: DW] = dat[g];
  end

  bitstream_buffer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .full      (full),
    .locked    (locked),
    .burst_err (burst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_pat();
    tagc++;
    for (int i = 0; i < N; i++) dat[i] = {16{{8'(i), 24'(tagc)}}};
    if (ovr_en) dat[ovr_src] = a5w;
  endtask

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy,
                     input logic [N-1:0] eg, input logic el, input logic frc = 1'b0);
    exp_t e;
    set_pat();
    req = r; req_last = l; out_ready = rdy;
    @(negedge clk);
    chk("gnt", DW'(gnt), DW'(eg));
    chk("locked", DW'(locked), DW'(el));
    if (eg != '0) begin
      for (int i = 0; i < N; i++)
        if (eg[i]) begin
          e.data = dat[i];
          e.src  = SW'(i);
          e.last = l[i] | frc;
        end
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_word: got src %0d with empty queue", out_src);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_src", DW'(out_src), DW'(e.src));
          chk("out_last", DW'(out_last), DW'(e.last));
        end
      end else if (!out_valid) begin
        chk("idle_data", out_data, '0);
      end
    end
  end

  initial begin
    a5w = {64{8'hA5}};
    ovr_en = 1'b0; ovr_src = 0; tagc = 0;
    set_pat();
    // Reset with all sources requesting
    reset_n = 1'b0; req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    #1;
    chk("rst_gnt", DW'(gnt), '0);
    @(negedge clk);
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_src", DW'(out_src), '0);
    chk("rst_last", DW'(out_last), '0);
    chk("rst_locked", DW'(locked), '0);
    chk("rst_err", DW'(burst_err), '0);
    chk("rst_gnt2", DW'(gnt), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Round robin, single-word packets
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    cyc(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Burst lock: source 2 three words while source 0 waits
    cyc(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0);
    cyc(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1);
    cyc(4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1);
    cyc(4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Backpressure holding the A5 word, then drain+refill in one cycle
    ovr_en = 1'b1; ovr_src = 1;
    cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0);
    ovr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0);
      chk("hold_data", out_data, a5w);
      chk("hold_full", DW'(full), DW'(1));
    end
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Owner stall: source 1 locked and idle, source 3 must wait
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) cyc(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1);
    cyc(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1);
    cyc(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

`ifdef BSA_BURST_LIMIT_EN
    // Burst limit 4: source 0 streams without last, source 1 waiting
    chk("err_before", DW'(burst_err), '0);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 1'b1);
    chk("burst_err", DW'(burst_err), DW'(1));
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b0);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    chk("err_sticky", DW'(burst_err), DW'(1));
`else
    chk("err_tied", DW'(burst_err), '0);
`endif

    // Reset in the middle of a burst drops the partial packet
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, LIM);
    cyc(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1);
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", DW'(out_valid), '0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_locked", DW'(locked), '0);
    chk("mid_rst_err", DW'(burst_err), '0);
    chk("mid_rst_gnt", DW'(gnt), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

    chk("queue_empty", DW'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bitstream_buffer_arbiter.md
Name: bitstream_buffer_arbiter

Overview:
- Shares one 512-bit single-entry bitstream holding register among NUM_REQ bitstream sources, such as per-channel LiDAR packet readers.
- Arbitrates round-robin with burst locking, so one source's multi-word packet reaches the bitstream reader contiguously.
- Presents a valid/ready output carrying the data, the source ID and a last-word flag.
- Sits between the packet ingest front-ends and the Bitstream Reader.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 512, bitstream word width.
- MAX_BURST, 16, maximum words per locked burst (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-source word-available flag.
- req_data  in  NUM_REQ*DATA_W  flattened words; source i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  word is the final word of that source's packet.
- gnt  out  NUM_REQ  one-hot accept pulse; the source's word is consumed in the cycle gnt[i]=1.
- out_valid  out  1  holding register occupied.
- out_ready  in  1  reader accepts out_data this cycle.
- out_data  out  DATA_W  held word; zero when out_valid=0.
- out_src  out  $clog2(NUM_REQ)  source index of the held word.
- out_last  out  1  held word closes its packet.
- full  out  1  equals out_valid.
- locked  out  1  a burst owner is currently fixed.
- burst_err  out  1  sticky; burst forcibly terminated (optional feature only, else tied 0).

Behaviour:
- Reset (async assert, sync deassert handled upstream): gnt=0, out_valid=0, out_data=0, out_src=0, out_last=0, locked=0, burst_err=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- Can-accept condition: can_acc = !out_valid || out_ready. A simultaneous drain and refill is allowed, so full throughput is 1 word per cycle.
- IDLE state:
  - If can_acc and any req is set, pick the first requester at or after rr_ptr, cyclically.
  - Assert gnt for that requester combinationally in the same cycle.
  - Load the holding register at the clock edge.
  - If req_last of the winner = 0, move to LOCKED with owner = winner and burst_cnt = 1.
  - rr_ptr <= winner+1, wrapping modulo NUM_REQ.
- LOCKED state:
  - Only the owner can be granted; other req lines are ignored.
  - Grant when can_acc and req[owner]; burst_cnt increments.
  - Owner's accepted word with req_last=1: return to IDLE and clear burst_cnt.
  - Owner deasserting req: stay LOCKED with no grant (a stalled packet is not interleaved).
- Latency: a word granted in cycle N is visible on out_data/out_valid in cycle N+1.
- Output hold: out_data, out_src and out_last stay stable while out_valid=1 and out_ready=0.
- No grant when can_acc=0, regardless of req.
- Registered outputs: gnt is combinational from registered state, req and out_ready; every other output is registered.
- Reset mid-burst: state and data clear immediately; the partial packet is dropped, and the source must resend it.

Optional Feature:
- Macro: BSA_BURST_LIMIT_EN.
- Defined:
  - When burst_cnt reaches MAX_BURST on an accepted word whose req_last=0, that word is forced to out_last=1.
  - The arbiter returns to IDLE and sets burst_err (sticky until reset).
  - The owner loses priority per rr_ptr.
- Not defined:
  - Bursts are unbounded, burst_cnt is omitted and burst_err is tied 0.

Decomposition:
- Package bsa_pkg:
  - Constants BSA_DATA_W=512 and BSA_SRC_W=$clog2(NUM_REQ default).
  - typedef enum {IDLE, LOCKED} bsa_state_t.
  - typedef struct {data, src, last} bsa_word_t.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs req and ptr; outputs one-hot grant plus its index.
  - Reusable by other arbiters.

Test Plan:
1. Reset then idle: reset_n=0 with req=4'b1111. Expect gnt=0, out_valid=0 and out_data=0. After release, expect the first gnt=4'b0001.
2. Round-robin: all req=1, req_last=1, out_ready=1. Expect the gnt sequence 0001, 0010, 0100, 1000, 0001, and out_src to follow 0, 1, 2, 3, 0 one cycle later.
3. Burst lock: source 2 sends 3 words (last on word 3) while source 0 requests. Expect source 2 granted 3 consecutive times, locked=1 for the first two words, then source 0 granted next.
4. Backpressure: out_ready=0 for 5 cycles with word 0xA5.. held. Expect no gnt, out_data stable, full=1. Then out_ready=1 plus a pending req gives drain and refill in the same cycle.
5. Owner stall: source 1 locked and deasserts req for 3 cycles while source 3 requests. Expect no gnt to source 3 until source 1 completes with last.
6. BSA_BURST_LIMIT_EN, MAX_BURST=4: source 0 streams 6 words with no last. Expect word 4 to have out_last=1, burst_err=1, and rr to move to source 1 if requesting.
